// File: rtl/mips_run_controller.sv
// mips_run_controller
//
// Run sequencer for an array of mips_cpu_harvard instances. Holds the CPUs in
// reset while idle, releases them on a start request after a fixed number of
// enabled reset cycles, checks that every CPU goes active, then gates the shared
// clock enable while counting RUN cycles. Each CPU's register_v0 is captured on
// the cycle it drops active. A cycle budget turns runaway programs into a fault.
//
// Optional feature: define MIPS_RUN_CTRL_HALT_STAMP_EN to implement per-CPU halt
// timestamps on halt_cycle. When it is undefined, halt_cycle is tied to zero.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   start          start request, honoured only in IDLE
//   clear          acknowledge, returns DONE/FAULT to IDLE
//   active         per-CPU active indication
//   register_v0    per-CPU v0 value, CPU i in bits [32i+31:32i]
//   cpu_reset      active-high synchronous reset to all CPUs
//   cpu_clk_enable shared CPU clock enable
//   busy           high in RESET, START and RUN
//   done           all CPUs halted normally
//   timeout        cycle budget exhausted
//   start_fault    a CPU failed to go active after reset
//   fault_mask     CPUs responsible for the fault
//   result         captured register_v0 per CPU
//   cycle_count    RUN cycles elapsed (saturating)
//   halt_cycle     per-CPU cycle_count value at halt
module mips_run_controller #(
    parameter int unsigned N_CPU          = 1,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned RESET_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic [N_CPU-1:0]         active,
    input  logic [32*N_CPU-1:0]      register_v0,
    output logic                     cpu_reset,
    output logic                     cpu_clk_enable,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic                     start_fault,
    output logic [N_CPU-1:0]         fault_mask,
    output logic [32*N_CPU-1:0]      result,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W*N_CPU-1:0]   halt_cycle
);

    localparam int unsigned RcW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StStart,
        StRun,
        StDone,
        StFault
    } state_e;

    state_e                 state_q, state_d;
    logic [RcW-1:0]         rst_cnt_q, rst_cnt_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   clk_en_q, clk_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   start_fault_q, start_fault_d;
    logic [N_CPU-1:0]       fault_mask_q, fault_mask_d;
    logic [32*N_CPU-1:0]    result_q, result_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [N_CPU-1:0]       halted_q, halted_d;
    logic [N_CPU-1:0]       capture;
    logic [N_CPU-1:0]       halted_nxt;
`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
    logic [CNT_W*N_CPU-1:0] halt_cycle_q, halt_cycle_d;
`endif

    // A CPU is captured only on its first inactive cycle in RUN.
    assign capture    = ~active & ~halted_q;
    assign halted_nxt = halted_q | capture;

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cpu_reset_d   = cpu_reset_q;
        clk_en_d      = clk_en_q;
        busy_d        = busy_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        start_fault_d = start_fault_q;
        fault_mask_d  = fault_mask_q;
        result_d      = result_q;
        cycle_count_d = cycle_count_q;
        halted_d      = halted_q;
`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
        halt_cycle_d  = halt_cycle_q;
`endif

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StReset;
                    rst_cnt_d     = RcW'(1);
                    cpu_reset_d   = 1'b1;
                    clk_en_d      = 1'b1;
                    busy_d        = 1'b1;
                    result_d      = '0;
                    cycle_count_d = '0;
                    fault_mask_d  = '0;
                    halted_d      = '0;
`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
                    halt_cycle_d  = '0;
`endif
                end
            end
            StReset: begin
                if (rst_cnt_q == RcW'(RESET_CYCLES)) begin
                    state_d     = StStart;
                    cpu_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RcW'(1);
                end
            end
            StStart: begin
                if (&active) begin
                    state_d = StRun;
                end else begin
                    state_d       = StFault;
                    start_fault_d = 1'b1;
                    fault_mask_d  = ~active;
                    clk_en_d      = 1'b0;
                    busy_d        = 1'b0;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(N_CPU); i++) begin
                    if (capture[i]) begin
                        result_d[32*i +: 32] = register_v0[32*i +: 32];
`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
                        halt_cycle_d[CNT_W*i +: CNT_W] = cycle_count_q;
`endif
                    end
                end
                halted_d = halted_nxt;
                // Completion is tested before the budget so a last halt on the
                // final budget cycle still ends in DONE.
                if (&halted_nxt) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    clk_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = StFault;
                    timeout_d    = 1'b1;
                    fault_mask_d = ~halted_nxt;
                    clk_en_d     = 1'b0;
                    busy_d       = 1'b0;
                end else if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
            end
            StDone, StFault: begin
                if (clear) begin
                    state_d       = StIdle;
                    cpu_reset_d   = 1'b1;
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    start_fault_d = 1'b0;
                    fault_mask_d  = '0;
                end
            end
            default: begin
                state_d     = StIdle;
                cpu_reset_d = 1'b1;
                clk_en_d    = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            rst_cnt_q     <= '0;
            cpu_reset_q   <= 1'b1;
            clk_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            start_fault_q <= 1'b0;
            fault_mask_q  <= '0;
            result_q      <= '0;
            cycle_count_q <= '0;
            halted_q      <= '0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cpu_reset_q   <= cpu_reset_d;
            clk_en_q      <= clk_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            start_fault_q <= start_fault_d;
            fault_mask_q  <= fault_mask_d;
            result_q      <= result_d;
            cycle_count_q <= cycle_count_d;
            halted_q      <= halted_d;
        end
    end

`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_cycle_q <= '0;
        end else begin
            halt_cycle_q <= halt_cycle_d;
        end
    end
    assign halt_cycle = halt_cycle_q;
`else
    assign halt_cycle = '0;
`endif

    assign cpu_reset      = cpu_reset_q;
    assign cpu_clk_enable = clk_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign start_fault    = start_fault_q;
    assign fault_mask     = fault_mask_q;
    assign result         = result_q;
    assign cycle_count    = cycle_count_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// Self-checking bench for mips_run_controller. Three instances share the clock
// and reset: u_a (1 CPU, default budget), u_b (1 CPU, budget 16, 3 reset
// cycles) and u_c (2 CPUs, budget 10).
module tb_mips_run_controller;

    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    // u_a signals
    logic        a_start, a_clear, a_act;
    logic [31:0] a_v0;
    logic        a_rst, a_en, a_busy, a_done, a_to, a_sf, a_fm;
    logic [31:0] a_res, a_cnt, a_hc;

    // u_b signals
    logic        b_start, b_clear, b_act;
    logic [31:0] b_v0;
    logic        b_rst, b_en, b_busy, b_done, b_to, b_sf, b_fm;
    logic [31:0] b_res;
    logic [7:0]  b_cnt, b_hc;

    // u_c signals
    logic        c_start, c_clear;
    logic [1:0]  c_act;
    logic [63:0] c_v0;
    logic        c_rst, c_en, c_busy, c_done, c_to, c_sf;
    logic [1:0]  c_fm;
    logic [63:0] c_res;
    logic [7:0]  c_cnt;
    logic [15:0] c_hc;

    mips_run_controller u_a (
        .clk(clk), .rst(rst_n), .start(a_start), .clear(a_clear), .active(a_act),
        .register_v0(a_v0), .cpu_reset(a_rst), .cpu_clk_enable(a_en), .busy(a_busy),
        .done(a_done), .timeout(a_to), .start_fault(a_sf), .fault_mask(a_fm),
        .result(a_res), .cycle_count(a_cnt), .halt_cycle(a_hc)
    );

    mips_run_controller #(
        .N_CPU(1), .TIMEOUT_CYCLES(16), .CNT_W(8), .RESET_CYCLES(3)
    ) u_b (
        .clk(clk), .rst(rst_n), .start(b_start), .clear(b_clear), .active(b_act),
        .register_v0(b_v0), .cpu_reset(b_rst), .cpu_clk_enable(b_en), .busy(b_busy),
        .done(b_done), .timeout(b_to), .start_fault(b_sf), .fault_mask(b_fm),
        .result(b_res), .cycle_count(b_cnt), .halt_cycle(b_hc)
    );

    mips_run_controller #(
        .N_CPU(2), .TIMEOUT_CYCLES(10), .CNT_W(8), .RESET_CYCLES(1)
    ) u_c (
        .clk(clk), .rst(rst_n), .start(c_start), .clear(c_clear), .active(c_act),
        .register_v0(c_v0), .cpu_reset(c_rst), .cpu_clk_enable(c_en), .busy(c_busy),
        .done(c_done), .timeout(c_to), .start_fault(c_sf), .fault_mask(c_fm),
        .result(c_res), .cycle_count(c_cnt), .halt_cycle(c_hc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        clear;
        logic        act;
        logic [31:0] v0;
        logic        e_rst;
        logic        e_en;
        logic        e_busy;
        logic        e_done;
        logic        e_sf;
        logic        e_fm;
        logic [31:0] e_res;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic s, input logic c, input logic a,
                                input logic [31:0] v, input logic r, input logic en,
                                input logic bz, input logic dn, input logic sf,
                                input logic fm, input logic [31:0] res,
                                input logic [31:0] cnt);
        vec_t t;
        t.start = s;   t.clear = c;   t.act = a;     t.v0 = v;
        t.e_rst = r;   t.e_en = en;   t.e_busy = bz; t.e_done = dn;
        t.e_sf = sf;   t.e_fm = fm;   t.e_res = res; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_hc_a;
    logic [63:0] exp_hc_c;

    initial begin
`ifdef MIPS_RUN_CTRL_HALT_STAMP_EN
        exp_hc_a = 64'd40;
        exp_hc_c = 64'h0905;
`else
        exp_hc_a = 64'd0;
        exp_hc_c = 64'd0;
`endif
        rst_n = 1'b0;
        a_start = 0; a_clear = 0; a_act = 0; a_v0 = '0;
        b_start = 0; b_clear = 0; b_act = 0; b_v0 = '0;
        c_start = 0; c_clear = 0; c_act = '0; c_v0 = '0;

        //            s  c  a  v0     rst en bsy dn sf fm res    cnt
        vecs[0]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h0,  0); // idle
        vecs[1]  = mk(1, 0, 0, 32'h0,  1, 1, 1, 0, 0, 0, 32'h0,  0); // RESET
        vecs[2]  = mk(0, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  0); // START
        vecs[3]  = mk(0, 0, 1, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  0); // RUN entry
        vecs[4]  = mk(0, 0, 1, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  1);
        vecs[5]  = mk(0, 0, 1, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  2);
        vecs[6]  = mk(0, 0, 0, 32'h55, 0, 0, 0, 1, 0, 0, 32'h55, 2); // halt
        vecs[7]  = mk(1, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0, 32'h55, 2); // start ignored
        vecs[8]  = mk(0, 1, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h55, 2); // clear
        vecs[9]  = mk(1, 0, 0, 32'h0,  1, 1, 1, 0, 0, 0, 32'h0,  0); // restart
        vecs[10] = mk(0, 0, 0, 32'h0,  0, 1, 1, 0, 0, 0, 32'h0,  0);
        vecs[11] = mk(0, 0, 0, 32'h0,  0, 0, 0, 0, 1, 1, 32'h0,  0); // start fault
        vecs[12] = mk(1, 1, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h0,  0); // start+clear
        vecs[13] = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h0,  0); // no new run

        // Reset values while reset is held.
        tick();
        tick();
        check("rst_cpu_reset", a_rst, 1);
        check("rst_enable", a_en, 0);
        check("rst_busy", a_busy, 0);
        check("rst_flags", {a_done, a_to, a_sf, a_fm}, 0);
        check("rst_result", a_res, 0);
        check("rst_count", a_cnt, 0);
        check("rst_halt_cycle", a_hc, 0);
        rst_n = 1'b1;

        // Table-driven sequence on u_a.
        for (int i = 0; i < 14; i++) begin
            a_start = vecs[i].start;
            a_clear = vecs[i].clear;
            a_act   = vecs[i].act;
            a_v0    = vecs[i].v0;
            tick();
            check($sformatf("vec%0d_cpu_reset", i), a_rst, vecs[i].e_rst);
            check($sformatf("vec%0d_enable", i), a_en, vecs[i].e_en);
            check($sformatf("vec%0d_busy", i), a_busy, vecs[i].e_busy);
            check($sformatf("vec%0d_done", i), a_done, vecs[i].e_done);
            check($sformatf("vec%0d_start_fault", i), a_sf, vecs[i].e_sf);
            check($sformatf("vec%0d_fault_mask", i), a_fm, vecs[i].e_fm);
            check($sformatf("vec%0d_result", i), a_res, vecs[i].e_res);
            check($sformatf("vec%0d_count", i), a_cnt, vecs[i].e_cnt);
        end
        a_start = 0; a_clear = 0;

        // 40-cycle program returning 0x2A.
        a_start = 1; tick();
        a_start = 0; tick();
        a_act = 1;   tick();
        repeat (40) tick();
        check("run40_busy", a_busy, 1);
        a_act = 0; a_v0 = 32'h2A;
        tick();
        check("run40_done", a_done, 1);
        check("run40_result", a_res, 32'h2A);
        check("run40_count", a_cnt, 40);
        check("run40_enable", a_en, 0);
        check("run40_timeout", a_to, 0);
        check("run40_halt_cycle", a_hc, exp_hc_a);
        a_clear = 1; tick();
        a_clear = 0;
        check("run40_clear_idle", {a_rst, a_done}, 2'b10);

        // Asynchronous reset in the middle of a run.
        a_start = 1; tick();
        a_start = 0; tick();
        a_act = 1;   tick();
        repeat (3) tick();
        check("midrst_pre_count", a_cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cpu_reset", a_rst, 1);
        check("midrst_enable", a_en, 0);
        check("midrst_busy", a_busy, 0);
        check("midrst_count", a_cnt, 0);
        #2 rst_n = 1'b1;
        a_act = 0;
        tick();
        check("midrst_stays_idle", {a_rst, a_busy}, 2'b10);

        // u_b: three reset cycles, then budget of 16 with the CPU never halting.
        b_start = 1; tick();
        b_start = 0;
        check("b_reset0", {b_rst, b_en}, 2'b11);
        tick();
        check("b_reset1", {b_rst, b_en}, 2'b11);
        tick();
        check("b_reset2", {b_rst, b_en}, 2'b11);
        tick();
        check("b_start_state", {b_rst, b_en}, 2'b01);
        b_act = 1; tick();
        repeat (15) tick();
        check("b_pre_timeout", {b_to, b_busy}, 2'b01);
        check("b_pre_count", b_cnt, 15);
        tick();
        check("b_timeout", b_to, 1);
        check("b_fault_mask", b_fm, 1);
        check("b_count", b_cnt, 15);
        check("b_enable", {b_en, b_busy, b_done}, 0);

        // u_c: CPU0 halts on cycle 5 then re-asserts, CPU1 halts on the final
        // budget cycle.
        c_start = 1; tick();
        c_start = 0; tick();
        c_act = 2'b11; tick();
        repeat (5) tick();
        c_act[0] = 1'b0; c_v0[31:0] = 32'd7;
        tick();
        check("c_cpu0_result", c_res, 64'd7);
        check("c_cpu0_not_done", c_done, 0);
        c_act[0] = 1'b1; c_v0[31:0] = 32'd99;
        repeat (3) tick();
        c_act[1] = 1'b0; c_v0[63:32] = 32'd9;
        tick();
        check("c_done", c_done, 1);
        check("c_timeout", c_to, 0);
        check("c_result", c_res, {32'd9, 32'd7});
        check("c_halt_cycle", c_hc, exp_hc_c);
        check("c_count", c_cnt, 9);
        check("c_enable", c_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
